// File: rtl/popcount_stream_if.sv
// Handshake bundle for popcount_stream: word input channel and result output channel.
interface popcount_stream_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = 16
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [ACC_W-1:0] out_total;
  logic             out_last;
  logic             out_sat;

  // Word source / result consumer side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_total, out_last, out_sat
  );

  // Counter block side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count, out_total, out_last, out_sat
  );
endinterface

// File: rtl/popcount_stream.sv
// Streaming popcount: nibble half-adder cells into S1, adder tree plus saturating
// per-frame accumulator into S2 (the output register). Whole pipe stalls on backpressure.
module popcount_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = 16
) (
  input logic              clk,
  input logic              rst,
  popcount_stream_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned NIB   = WIDTH / 4;
  // Wide enough that a full-word count never truncates before the clamp compare
  localparam int unsigned SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

  // Two half adders per bit pair, then combine; weight-2 carries never all three set
  function automatic logic [2:0] nib_count(input logic [3:0] n);
    logic s0, c0, s1, c1, c2;
    s0 = n[0] ^ n[1];
    c0 = n[0] & n[1];
    s1 = n[2] ^ n[3];
    c1 = n[2] & n[3];
    c2 = s0 & s1;
    return {c0 & c1, c0 ^ c1 ^ c2, s0 ^ s1};
  endfunction

  logic                en;
  logic [NIB-1:0][2:0] s1_cnt_q, s1_cnt_d;
  logic                s1_last_q, s1_last_d;
  logic                s1_valid_q, s1_valid_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic [ACC_W-1:0]    out_total_q, out_total_d;
  logic                out_last_q, out_last_d;
  logic                out_sat_q, out_sat_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                acc_sat_q, acc_sat_d;
  logic [CNT_W-1:0]    word_cnt;
  logic [SUM_W-1:0]    sum_ext;
  logic                over;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en && !rst;

  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.out_total = out_total_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sat   = out_sat_q;

  // Adder tree over S1 nibble counts and saturating add into the frame total
  always_comb begin : tree_sum
    word_cnt = '0;
    for (int i = 0; i < int'(NIB); i++) begin
      word_cnt = word_cnt + CNT_W'(s1_cnt_q[i]);
    end
    sum_ext = SUM_W'(acc_q) + SUM_W'(word_cnt);
    over    = sum_ext > ACC_MAX;
  end

  always_comb begin : next_state
    s1_cnt_d    = s1_cnt_q;
    s1_last_d   = s1_last_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_total_d = out_total_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    acc_d       = acc_q;
    acc_sat_d   = acc_sat_q;
    if (en) begin
      s1_valid_d = bus.in_valid;
      s1_last_d  = bus.in_last;
      for (int i = 0; i < int'(NIB); i++) begin
        s1_cnt_d[i] = nib_count(bus.in_data[4*i +: 4]);
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_count_d = word_cnt;
        out_total_d = over ? '1 : sum_ext[ACC_W-1:0];
        out_sat_d   = acc_sat_q | over;
        out_last_d  = s1_last_q;
        // A frame's last word reports its total, then the next word starts from zero
        acc_d       = s1_last_q ? '0 : out_total_d;
        acc_sat_d   = s1_last_q ? 1'b0 : out_sat_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_cnt_q    <= '0;
      s1_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_total_q <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      acc_sat_q   <= 1'b0;
    end else begin
      s1_cnt_q    <= s1_cnt_d;
      s1_last_q   <= s1_last_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_total_q <= out_total_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      acc_q       <= acc_d;
      acc_sat_q   <= acc_sat_d;
    end
  end
endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: two instances (ACC_W=16 and ACC_W=5) share one stimulus
// stream and are checked every cycle against a queue-based frame-total model.
module tb_popcount_stream;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 31;

  typedef struct {
    int cnt;
    int tot_a;
    bit sat_a;
    int tot_b;
    bit sat_b;
    bit last;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  int n_vec = 0;
  int n_err = 0;

  res_t exp_q[$];
  res_t log_q[$];
  res_t cmp_e;
  res_t cmp_r;
  int   acc_a, acc_b;
  bit   sat_a, sat_b;

  popcount_stream_if #(.WIDTH(16), .ACC_W(16)) if_a ();
  popcount_stream_if #(.WIDTH(16), .ACC_W(5))  if_b ();

  assign if_a.in_valid  = in_valid;
  assign if_a.in_data   = in_data;
  assign if_a.in_last   = in_last;
  assign if_a.out_ready = out_ready;
  assign if_b.in_valid  = in_valid;
  assign if_b.in_data   = in_data;
  assign if_b.in_last   = in_last;
  assign if_b.out_ready = out_ready;

  popcount_stream #(.WIDTH(16), .ACC_W(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  popcount_stream #(.WIDTH(16), .ACC_W(5))  dut_b (.clk(clk), .rst(rst), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: per-word popcount and clamped frame totals for both accumulator widths
  function automatic void model_push(input logic [15:0] d, input logic l);
    res_t e;
    int   c;
    c     = $countones(d);
    e.cnt = c;
    if (acc_a + c > MAX_A) begin e.tot_a = MAX_A; e.sat_a = 1'b1; end
    else begin e.tot_a = acc_a + c; e.sat_a = sat_a; end
    if (acc_b + c > MAX_B) begin e.tot_b = MAX_B; e.sat_b = 1'b1; end
    else begin e.tot_b = acc_b + c; e.sat_b = sat_b; end
    e.last = l;
    if (l) begin
      acc_a = 0; sat_a = 1'b0; acc_b = 0; sat_b = 1'b0;
    end else begin
      acc_a = e.tot_a; sat_a = e.sat_a; acc_b = e.tot_b; sat_b = e.sat_b;
    end
    exp_q.push_back(e);
  endfunction

  // Per-cycle compare; signals are stable here until the next rising edge
  always @(negedge clk) begin
    chk("in_ready", if_a.in_ready, !rst && (!if_a.out_valid || out_ready));
    if (if_a.out_valid || if_b.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", {if_a.out_valid, if_b.out_valid}, 0);
      end else begin
        cmp_e = exp_q[0];
        chk("valid_a", if_a.out_valid, 1);
        chk("valid_b", if_b.out_valid, 1);
        chk("count_a", if_a.out_count, cmp_e.cnt);
        chk("count_b", if_b.out_count, cmp_e.cnt);
        chk("total_a", if_a.out_total, cmp_e.tot_a);
        chk("sat_a", if_a.out_sat, cmp_e.sat_a);
        chk("total_b", if_b.out_total, cmp_e.tot_b);
        chk("sat_b", if_b.out_sat, cmp_e.sat_b);
        chk("last_a", if_a.out_last, cmp_e.last);
        chk("last_b", if_b.out_last, cmp_e.last);
        if (out_ready) begin
          cmp_r.cnt   = int'(if_a.out_count);
          cmp_r.tot_a = int'(if_a.out_total);
          cmp_r.sat_a = if_a.out_sat;
          cmp_r.tot_b = int'(if_b.out_total);
          cmp_r.sat_b = if_b.out_sat;
          cmp_r.last  = if_a.out_last;
          log_q.push_back(cmp_r);
          void'(exp_q.pop_front());
        end
      end
    end
    if (in_valid && if_a.in_ready) model_push(in_data, in_last);
    if (rst) begin
      exp_q.delete();
      acc_a = 0; sat_a = 1'b0; acc_b = 0; sat_b = 1'b0;
    end
  end

  // Call #1 after a rising edge; returns #1 after the edge that accepted the word
  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!if_a.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", n < 50, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((exp_q.size() != 0 || if_a.out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", n < 50, 1);
  endtask

  task automatic expect_log(input string name, input int idx, input int cnt, input int ta,
                            input bit sa, input int tb_tot, input bit sb, input bit l);
    chk({name, "_present"}, log_q.size() > idx, 1);
    if (log_q.size() > idx) begin
      chk({name, "_cnt"}, log_q[idx].cnt, cnt);
      chk({name, "_tot_a"}, log_q[idx].tot_a, ta);
      chk({name, "_sat_a"}, log_q[idx].sat_a, sa);
      chk({name, "_tot_b"}, log_q[idx].tot_b, tb_tot);
      chk({name, "_sat_b"}, log_q[idx].sat_b, sb);
      chk({name, "_last"}, log_q[idx].last, l);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    acc_a = 0; acc_b = 0; sat_a = 1'b0; sat_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", if_a.out_valid, 0);
    chk("rst_count", if_a.out_count, 0);
    chk("rst_total_a", if_a.out_total, 0);
    chk("rst_total_b", if_b.out_total, 0);
    chk("rst_last", if_a.out_last, 0);
    chk("rst_sat", if_a.out_sat, 0);
    chk("rst_in_ready", if_a.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", if_a.in_ready, 1);
    @(posedge clk); #1;

    // Single word: S1 after the accepting edge, result one edge later
    send(16'hFFFF, 1'b1);
    chk("lat_s1_valid", if_a.out_valid, 0);
    @(posedge clk); #1;
    chk("single_valid", if_a.out_valid, 1);
    chk("single_count", if_a.out_count, 16);
    chk("single_total", if_a.out_total, 16);
    chk("single_last", if_a.out_last, 1);
    chk("single_sat", if_a.out_sat, 0);
    drain();

    log_q.delete();
    send(16'h0001, 1'b0);
    send(16'h00FF, 1'b0);
    send(16'hFFFF, 1'b1);
    send(16'h0003, 1'b1);
    drain();
    expect_log("frame0", 0, 1, 1, 0, 1, 0, 0);
    expect_log("frame1", 1, 8, 9, 0, 9, 0, 0);
    expect_log("frame2", 2, 16, 25, 0, 25, 0, 1);
    expect_log("frame3", 3, 2, 2, 0, 2, 0, 1);

    log_q.delete();
    send(16'h0007, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    send(16'h0001, 1'b1);
    drain();
    expect_log("bubble0", 0, 3, 3, 0, 3, 0, 0);
    expect_log("bubble1", 1, 1, 4, 0, 4, 0, 1);

    log_q.delete();
    out_ready = 1'b0;
    fork
      begin
        send(16'h1111, 1'b0);
        send(16'h00F0, 1'b0);
        send(16'h8001, 1'b0);
        send(16'hFFFF, 1'b1);
      end
      begin : bp_watch
        int n;
        n = 0;
        @(negedge clk);
        while (!if_a.out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("bp_first_timeout", n < 20, 1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold_valid", if_a.out_valid, 1);
          chk("bp_hold_count", if_a.out_count, 4);
          chk("bp_hold_total", if_a.out_total, 4);
          chk("bp_hold_last", if_a.out_last, 0);
          chk("bp_in_ready", if_a.in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    expect_log("bp0", 0, 4, 4, 0, 4, 0, 0);
    expect_log("bp1", 1, 4, 8, 0, 8, 0, 0);
    expect_log("bp2", 2, 2, 10, 0, 10, 0, 0);
    expect_log("bp3", 3, 16, 26, 0, 26, 0, 1);

    log_q.delete();
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b1);
    send(16'h000F, 1'b1);
    drain();
    expect_log("sat0", 0, 16, 16, 0, 16, 0, 0);
    expect_log("sat1", 1, 16, 32, 0, 31, 1, 0);
    expect_log("sat2", 2, 16, 48, 0, 31, 1, 1);
    expect_log("sat3", 3, 4, 4, 0, 4, 0, 1);

    send(16'h00FF, 1'b0);
    send(16'h0F0F, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid_a", if_a.out_valid, 0);
    chk("midrst_valid_b", if_b.out_valid, 0);
    chk("midrst_total_a", if_a.out_total, 0);
    chk("midrst_total_b", if_b.out_total, 0);
    rst = 1'b0;
    log_q.delete();
    send(16'h0001, 1'b1);
    drain();
    expect_log("midrst_next", 0, 1, 1, 0, 1, 0, 1);

    // Random traffic with backpressure, bubbles, frames and occasional reset
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       in_data = 16'hFFFF;
        1:       in_data = 16'h0000;
        default: in_data = 16'($urandom);
      endcase
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
